// File: rtl/stopwatch_bcd_if.sv
// Button inputs and display outputs of the BCD stopwatch, grouped for the scan-stage hookup.
// dbg_state mirrors the control FSM state (0 IDLE, 1 RUN, 2 STOP).
interface stopwatch_bcd_if;
  logic       btn_start;
  logic       btn_clear;
  logic [3:0] num1;
  logic [3:0] num2;
  logic [3:0] num3;
  logic [3:0] num4;
  logic [3:0] dp_n;
  logic       running;
  logic       ovf;
  logic [1:0] dbg_state;

  modport master (output btn_start, btn_clear,
                  input  num1, num2, num3, num4, dp_n, running, ovf, dbg_state);
  modport slave  (input  btn_start, btn_clear,
                  output num1, num2, num3, num4, dp_n, running, ovf, dbg_state);
endinterface

// File: rtl/stopwatch_bcd.sv
// SS.hh BCD stopwatch: debounced start/clear buttons, IDLE/RUN/STOP control, prescaled BCD cascade.
// Optional lap-hold display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_bcd #(
  parameter int TICK_DIV   = 500000,
  parameter int DEB_CYCLES = 500000
) (
  input logic           fin,
  input logic           rst_n,
  stopwatch_bcd_if.slave sw
);
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;

  // Index 0 is start, index 1 is clear.
  logic [1:0]       w_raw;
  logic [1:0]       r_s1, r_s2, r_acc, r_ev;
  logic [DEB_W-1:0] r_deb_cnt [2];
  logic             w_ev_start, w_ev_clear;

  assign w_raw      = {sw.btn_clear, sw.btn_start};
  assign w_ev_start = r_ev[0];
  assign w_ev_clear = r_ev[1];

  always_ff @(posedge fin or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_acc <= '0;
      r_ev <= '0;
      for (int i = 0; i < 2; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
      r_ev <= '0;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_acc[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_W'(DEB_CYCLES)) begin
          r_acc[i]     <= r_s2[i];
          r_deb_cnt[i] <= '0;
          r_ev[i]      <= r_s2[i];
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  state_t r_state, w_state_nxt;
  logic   w_do_clear, w_pre_zero;

  always_ff @(posedge fin or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Start wins in RUN; clear wins in IDLE/STOP.
  always_comb begin
    w_state_nxt = r_state;
    w_do_clear  = 1'b0;
    w_pre_zero  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ev_clear) begin
          w_do_clear = 1'b1;
        end else if (w_ev_start) begin
          w_state_nxt = RUN;
          w_pre_zero  = 1'b1;
        end
      end
      RUN: begin
        if (w_ev_start) w_state_nxt = STOP;
      end
      STOP: begin
        if (w_ev_clear) begin
          w_do_clear  = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_ev_start) begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  logic [PRE_W-1:0] r_pre;
  logic             r_tick;

  always_ff @(posedge fin or negedge rst_n) begin
    if (!rst_n) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (w_do_clear || w_pre_zero) begin
        r_pre <= '0;
      end else if (r_state == RUN) begin
        if (r_pre == PRE_W'(TICK_DIV - 1)) begin
          r_pre  <= '0;
          r_tick <= 1'b1;
        end else begin
          r_pre <= r_pre + 1'b1;
        end
      end
    end
  end

  logic [3:0] r_d1, r_d2, r_d3, r_d4;
  logic       r_ovf;

  always_ff @(posedge fin or negedge rst_n) begin
    if (!rst_n) begin
      {r_d1, r_d2, r_d3, r_d4} <= '0;
      r_ovf <= 1'b0;
    end else if (w_do_clear) begin
      {r_d1, r_d2, r_d3, r_d4} <= '0;
      r_ovf <= 1'b0;
    end else if (r_tick) begin
      if (r_d4 == 4'd9) begin
        r_d4 <= 4'd0;
        if (r_d3 == 4'd9) begin
          r_d3 <= 4'd0;
          if (r_d2 == 4'd9) begin
            r_d2 <= 4'd0;
            if (r_d1 == 4'd5) begin
              r_d1  <= 4'd0;
              r_ovf <= 1'b1;
            end else begin
              r_d1 <= r_d1 + 4'd1;
            end
          end else begin
            r_d2 <= r_d2 + 4'd1;
          end
        end else begin
          r_d3 <= r_d3 + 4'd1;
        end
      end else begin
        r_d4 <= r_d4 + 4'd1;
      end
    end
  end

  logic [15:0] w_live, w_disp;
  assign w_live = {r_d1, r_d2, r_d3, r_d4};

`ifdef STOPWATCH_LAP_EN
  logic        w_lap_toggle, w_leave_run;
  logic        r_lap;
  logic [15:0] r_snap;

  assign w_lap_toggle = (r_state == RUN) && w_ev_clear && !w_ev_start;
  assign w_leave_run  = (r_state == RUN) && (w_state_nxt != RUN);

  // Snapshot is taken from the live count visible during the event cycle.
  always_ff @(posedge fin or negedge rst_n) begin
    if (!rst_n) begin
      r_lap  <= 1'b0;
      r_snap <= '0;
    end else if (w_leave_run) begin
      r_lap <= 1'b0;
    end else if (w_lap_toggle) begin
      r_lap <= ~r_lap;
      if (!r_lap) r_snap <= w_live;
    end
  end

  assign w_disp = r_lap ? r_snap : w_live;
`else
  assign w_disp = w_live;
`endif

  assign {sw.num1, sw.num2, sw.num3, sw.num4} = w_disp;
  assign sw.dp_n      = 4'b0100;
  assign sw.running   = (r_state == RUN);
  assign sw.ovf       = r_ovf;
  assign sw.dbg_state = r_state;
endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed bench for stopwatch_bcd with an arithmetic run-time model and expected-value queue.
// Define STOPWATCH_LAP_EN for both RTL and bench to exercise the lap-hold display.
module tb_stopwatch_bcd;
  localparam int TD = 10;
  localparam int DB = 4;
  // Raw press to state change: 2 sync + DB + 1 to the event, +1 to the state register.
  localparam int EV_LAT = 2 + DB + 1 + 1;

  logic fin = 1'b0;
  logic rst_n = 1'b0;
  stopwatch_bcd_if sw ();

  stopwatch_bcd #(.TICK_DIV(TD), .DEB_CYCLES(DB)) dut (
    .fin   (fin),
    .rst_n (rst_n),
    .sw    (sw)
  );

  always #5 fin = ~fin;

  int cyc = 0;
  always @(posedge fin) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  logic [16:0] exp_q[$];

  // Model: accumulated RUN edges, edge of current RUN entry (-1 when not running), lap state.
  int m_acc = 0;
  int m_entry = -1;
  bit m_lap = 0;
  int m_snap = 0;

  function automatic int m_count(int c);
    int r;
    r = m_acc + ((m_entry >= 0) ? (c - 1 - m_entry) : 0);
    return r / TD;
  endfunction

  function automatic logic [16:0] m_view(int c);
    int t;
    logic ov;
    t  = m_count(c);
    ov = (t >= 6000);
    if (m_lap) t = m_snap;
    t = t % 6000;
    return {ov, 4'(t / 1000), 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)};
  endfunction

  task automatic wait_cycles(int n);
    repeat (n) begin
      @(posedge fin);
      #1;
    end
  endtask

  task automatic press(bit s, bit c, int hold);
    sw.btn_start = s;
    sw.btn_clear = c;
    wait_cycles(hold);
    sw.btn_start = 1'b0;
    sw.btn_clear = 1'b0;
  endtask

  task automatic model_stop(int e);
    m_acc   = m_acc + (e - m_entry);
    m_entry = -1;
    m_lap   = 0;
  endtask

  task automatic model_clear();
    m_acc   = 0;
    m_entry = -1;
  endtask

  task automatic ev_start();
    int e;
    e = cyc + EV_LAT;
    if (m_entry >= 0) model_stop(e);
    else m_entry = e;
    press(1'b1, 1'b0, 20);
  endtask

  task automatic ev_clear();
    int e;
    e = cyc + EV_LAT;
    if (m_entry < 0) begin
      model_clear();
    end else begin
`ifdef STOPWATCH_LAP_EN
      if (!m_lap) begin
        m_snap = m_count(e - 1);
        m_lap  = 1;
      end else begin
        m_lap = 0;
      end
`endif
    end
    press(1'b0, 1'b1, 20);
  endtask

  task automatic ev_both();
    int e;
    e = cyc + EV_LAT;
    if (m_entry >= 0) model_stop(e);
    else model_clear();
    press(1'b1, 1'b1, 20);
  endtask

  task automatic expect_after(int n, string tag);
    logic [16:0] got, exp;
    exp_q.push_back(m_view(cyc + n));
    wait_cycles(n);
    got = {sw.ovf, sw.num1, sw.num2, sw.num3, sw.num4};
    exp = exp_q.pop_front();
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_val(string tag, logic [15:0] obs, logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    sw.btn_start = 1'b0;
    sw.btn_clear = 1'b0;
    rst_n = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(2);

    expect_after(1, "reset_digits");
    check_val("reset_dp", 16'(sw.dp_n), 16'h4);
    check_val("reset_running", 16'(sw.running), 16'h0);
    check_val("reset_state", 16'(sw.dbg_state), 16'h0);

    press(1'b1, 1'b0, 3);
    wait_cycles(20);
    check_val("glitch_running", 16'(sw.running), 16'h0);
    expect_after(1, "glitch_digits");

    ev_start();
    check_val("start_running", 16'(sw.running), 16'h1);
    wait_cycles(20);
    check_val("release_no_event", 16'(sw.running), 16'h1);
    expect_after(5, "pre_reset_count");

    rst_n = 1'b0;
    wait_cycles(2);
    check_val("in_reset_running", 16'(sw.running), 16'h0);
    rst_n = 1'b1;
    model_clear();
    expect_after(2, "reset_mid_digits");
    check_val("reset_mid_running", 16'(sw.running), 16'h0);
    check_val("reset_mid_dp", 16'(sw.dp_n), 16'h4);

    ev_start();
    expect_after(m_entry + 1005 - cyc, "count_01_00");
    ev_start();
    check_val("stop_running", 16'(sw.running), 16'h0);
    check_val("stop_state", 16'(sw.dbg_state), 16'h2);
    expect_after(1, "stop_value");
    expect_after(500, "stop_hold");
    ev_start();
    check_val("resume_running", 16'(sw.running), 16'h1);
    expect_after(40, "resume_count");

`ifndef STOPWATCH_LAP_EN
    ev_clear();
    check_val("clear_in_run_ignored", 16'(sw.running), 16'h1);
    expect_after(30, "clear_in_run_live");
`endif

    expect_after(60000, "wrap_ovf");
    expect_after(100, "wrap_continues");

    ev_start();
    check_val("wrap_stop", 16'(sw.running), 16'h0);
    ev_clear();
    expect_after(2, "clear_in_stop");
    check_val("clear_state_idle", 16'(sw.dbg_state), 16'h0);

    ev_start();
    wait_cycles(200);
    ev_both();
    check_val("both_run_state", 16'(sw.dbg_state), 16'h2);
    expect_after(50, "both_run_digits");
    ev_both();
    check_val("both_stop_state", 16'(sw.dbg_state), 16'h0);
    expect_after(2, "both_stop_zero");

`ifdef STOPWATCH_LAP_EN
    ev_start();
    wait_cycles(m_entry + 299 - cyc);
    ev_clear();
    check_val("lap_running", 16'(sw.running), 16'h1);
    expect_after(80, "lap_frozen");
    wait_cycles(100);
    ev_clear();
    expect_after(1, "lap_release");
    ev_start();
    check_val("lap_stop_state", 16'(sw.dbg_state), 16'h2);
    expect_after(3, "lap_stop_live");
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
